// File: rtl/memory_tester_pkg.sv
// Shared types and helpers for the memory built-in self-test initiator.
package memory_tester_pkg;

    // Sequencer states: one write sweep, one read sweep, one trailing compare.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Working width for pattern arithmetic; callers truncate to DATA_WIDTH.
    localparam int PAT_W = 32;

    // Test pattern for a word: its address XOR the seed. Because XOR is
    // bitwise, truncating after the XOR equals truncating both operands first.
    function automatic logic [PAT_W-1:0] pattern(
        input logic [PAT_W-1:0] addr,
        input logic [PAT_W-1:0] seed
    );
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/memory_tester_checker.sv
// Read-back checker: delays each issued read by one cycle to line up with the
// memory's registered output, compares against the expected pattern, counts
// mismatches (saturating) and remembers the address of the first one.
module memory_tester_checker
    import memory_tester_pkg::*;
#(
    parameter int          MEM_SIZE   = 8,
    parameter int          DATA_WIDTH = 8,
    parameter logic [31:0] SEED       = 32'h0000_005A
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_i,
    input  logic [MEM_SIZE-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0] mem_out_i,
    input  logic                  clear_i,
    output logic [MEM_SIZE:0]     errors_o,
    output logic [MEM_SIZE-1:0]   first_fail_o,
    output logic                  clean_next_o
);

    localparam int                EW       = MEM_SIZE + 1;
    localparam logic [EW-1:0]     ERR_ONE  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]     ERR_ZERO = {EW{1'b0}};
    localparam logic [EW-1:0]     ERR_MAX  = {EW{1'b1}};

    logic                  valid_q;
    logic [MEM_SIZE-1:0]   addr_q;
    logic [EW-1:0]         errors_q;
    logic [EW-1:0]         errors_d;
    logic [MEM_SIZE-1:0]   first_fail_q;
    logic [MEM_SIZE-1:0]   first_fail_d;
    logic [DATA_WIDTH-1:0] expected_s;
    logic                  mismatch_s;

    assign expected_s = DATA_WIDTH'(pattern(PAT_W'(addr_q), SEED));
    assign mismatch_s = valid_q && (mem_out_i != expected_s);

    // Delay the read strobe and address by one cycle to meet the read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= {MEM_SIZE{1'b0}};
        end else if (clear_i) begin
            valid_q <= 1'b0;
            addr_q  <= {MEM_SIZE{1'b0}};
        end else begin
            valid_q <= issue_i;
            addr_q  <= addr_i;
        end
    end

    // Next error count and first-failure address from this cycle's compare.
    always_comb begin
        errors_d     = errors_q;
        first_fail_d = first_fail_q;
        if (clear_i) begin
            errors_d     = ERR_ZERO;
            first_fail_d = {MEM_SIZE{1'b0}};
        end else if (mismatch_s) begin
            if (errors_q != ERR_MAX) begin
                errors_d = errors_q + ERR_ONE;
            end else begin
                errors_d = errors_q;
            end
            if (errors_q == ERR_ZERO) begin
                first_fail_d = addr_q;
            end else begin
                first_fail_d = first_fail_q;
            end
        end else begin
            errors_d     = errors_q;
            first_fail_d = first_fail_q;
        end
    end

    // Hold the error count and first failing address between tests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errors_q     <= ERR_ZERO;
            first_fail_q <= {MEM_SIZE{1'b0}};
        end else begin
            errors_q     <= errors_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign errors_o     = errors_q;
    assign first_fail_o = first_fail_q;
    // Lets the sequencer register pass on the same edge as the final compare.
    assign clean_next_o = (errors_d == ERR_ZERO);

endmodule

// File: rtl/memory_tester.sv
// Memory BIST initiator: writes pattern(a) to COUNT words from address 0,
// reads them back, and reports pass/fail, error count and first failure.
module memory_tester
    import memory_tester_pkg::*;
#(
    parameter int          MEM_SIZE   = 8,
    parameter int          DATA_WIDTH = 8,
    parameter int          COUNT      = 2 ** MEM_SIZE,
    parameter logic [31:0] SEED       = 32'h0000_005A
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_write,
    output logic [MEM_SIZE-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0] mem_in,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [MEM_SIZE:0]     errors,
    output logic [MEM_SIZE-1:0]   first_fail
);

    // One extra bit so COUNT = 2**MEM_SIZE is reachable without wrapping.
    localparam int               CNT_W    = MEM_SIZE + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;       // next address to present
    logic                  mem_write_q;
    logic [MEM_SIZE-1:0]   mem_address_q;
    logic [DATA_WIDTH-1:0] mem_in_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;

    logic                  start_accept_s;
    logic                  last_s;
    logic                  issue_s;
    logic                  clean_next_s;
    logic [DATA_WIDTH-1:0] cnt_pattern_s;

    assign start_accept_s = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_s         = (cnt_q == CNT_LAST);
    assign issue_s        = (state_q == READ);
    assign cnt_pattern_s  = DATA_WIDTH'(pattern(PAT_W'(cnt_q), SEED));

    // Sequencer: walks the write sweep, the read sweep and the drain compare,
    // registering every memory-side and status output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= CNT_ZERO;
            mem_write_q   <= 1'b0;
            mem_address_q <= {MEM_SIZE{1'b0}};
            mem_in_q      <= {DATA_WIDTH{1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_accept_s) begin
                        // Present address 0 immediately; counter points at 1.
                        state_q       <= WRITE;
                        cnt_q         <= CNT_ONE;
                        mem_write_q   <= 1'b1;
                        mem_address_q <= {MEM_SIZE{1'b0}};
                        mem_in_q      <= DATA_WIDTH'(pattern(PAT_W'(0), SEED));
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                    end else begin
                        cnt_q         <= CNT_ZERO;
                        mem_write_q   <= 1'b0;
                        mem_address_q <= {MEM_SIZE{1'b0}};
                        mem_in_q      <= {DATA_WIDTH{1'b0}};
                    end
                end
                WRITE: begin
                    if (last_s) begin
                        // Last word written; start reading from address 0.
                        state_q       <= READ;
                        cnt_q         <= CNT_ONE;
                        mem_write_q   <= 1'b0;
                        mem_address_q <= {MEM_SIZE{1'b0}};
                        mem_in_q      <= {DATA_WIDTH{1'b0}};
                    end else begin
                        cnt_q         <= cnt_q + CNT_ONE;
                        mem_write_q   <= 1'b1;
                        mem_address_q <= cnt_q[MEM_SIZE-1:0];
                        mem_in_q      <= cnt_pattern_s;
                    end
                end
                READ: begin
                    if (last_s) begin
                        // Last read issued; one more cycle for its compare.
                        state_q       <= DRAIN;
                        cnt_q         <= CNT_ZERO;
                        mem_address_q <= {MEM_SIZE{1'b0}};
                    end else begin
                        cnt_q         <= cnt_q + CNT_ONE;
                        mem_address_q <= cnt_q[MEM_SIZE-1:0];
                    end
                    mem_write_q <= 1'b0;
                    mem_in_q    <= {DATA_WIDTH{1'b0}};
                end
                DRAIN: begin
                    state_q       <= DONE;
                    cnt_q         <= CNT_ZERO;
                    mem_write_q   <= 1'b0;
                    mem_address_q <= {MEM_SIZE{1'b0}};
                    mem_in_q      <= {DATA_WIDTH{1'b0}};
                    busy_q        <= 1'b0;
                    done_q        <= 1'b1;
                    pass_q        <= clean_next_s;
                end
                default: begin
                    state_q       <= IDLE;
                    cnt_q         <= CNT_ZERO;
                    mem_write_q   <= 1'b0;
                    mem_address_q <= {MEM_SIZE{1'b0}};
                    mem_in_q      <= {DATA_WIDTH{1'b0}};
                    busy_q        <= 1'b0;
                    done_q        <= 1'b0;
                    pass_q        <= 1'b0;
                end
            endcase
        end
    end

    memory_tester_checker #(
        .MEM_SIZE   (MEM_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .SEED       (SEED)
    ) u_checker (
        .clk          (clk),
        .reset        (reset),
        .issue_i      (issue_s),
        .addr_i       (mem_address_q),
        .mem_out_i    (mem_out),
        .clear_i      (start_accept_s),
        .errors_o     (errors),
        .first_fail_o (first_fail),
        .clean_next_o (clean_next_s)
    );

    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_in      = mem_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_memory_tester.sv
// Self-checking bench: three tester configurations, each beside a behavioural
// single-port memory with a read-side corruption mask.
module tb_memory_tester;

    localparam int NI = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start [NI];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    // Instance A: MEM_SIZE 8, COUNT 4. B: MEM_SIZE 3, COUNT 8. C: 4-bit data, COUNT 1.
    logic       a_wr, a_busy, a_done, a_pass;
    logic [7:0] a_addr, a_in, a_out, a_ff;
    logic [8:0] a_err;
    logic       b_wr, b_busy, b_done, b_pass;
    logic [2:0] b_addr, b_ff;
    logic [7:0] b_in, b_out;
    logic [3:0] b_err;
    logic       c_wr, c_busy, c_done, c_pass;
    logic [1:0] c_addr, c_ff;
    logic [3:0] c_in, c_out;
    logic [2:0] c_err;

    memory_tester #(.MEM_SIZE(8), .DATA_WIDTH(8), .COUNT(4), .SEED(32'h5A)) dut_a (
        .clk(clk), .reset(reset), .start(start[0]), .mem_write(a_wr), .mem_address(a_addr),
        .mem_in(a_in), .mem_out(a_out), .busy(a_busy), .done(a_done), .pass(a_pass),
        .errors(a_err), .first_fail(a_ff));
    memory_tester #(.MEM_SIZE(3), .DATA_WIDTH(8), .COUNT(8), .SEED(32'h5A)) dut_b (
        .clk(clk), .reset(reset), .start(start[1]), .mem_write(b_wr), .mem_address(b_addr),
        .mem_in(b_in), .mem_out(b_out), .busy(b_busy), .done(b_done), .pass(b_pass),
        .errors(b_err), .first_fail(b_ff));
    memory_tester #(.MEM_SIZE(2), .DATA_WIDTH(4), .COUNT(1), .SEED(32'h5A)) dut_c (
        .clk(clk), .reset(reset), .start(start[2]), .mem_write(c_wr), .mem_address(c_addr),
        .mem_in(c_in), .mem_out(c_out), .busy(c_busy), .done(c_done), .pass(c_pass),
        .errors(c_err), .first_fail(c_ff));

    logic        o_wr [NI], o_busy [NI], o_done [NI], o_pass [NI];
    logic [31:0] o_addr [NI], o_in [NI], o_err [NI], o_ff [NI];

    always_comb begin
        o_wr[0] = a_wr; o_busy[0] = a_busy; o_done[0] = a_done; o_pass[0] = a_pass;
        o_addr[0] = 32'(a_addr); o_in[0] = 32'(a_in); o_err[0] = 32'(a_err); o_ff[0] = 32'(a_ff);
        o_wr[1] = b_wr; o_busy[1] = b_busy; o_done[1] = b_done; o_pass[1] = b_pass;
        o_addr[1] = 32'(b_addr); o_in[1] = 32'(b_in); o_err[1] = 32'(b_err); o_ff[1] = 32'(b_ff);
        o_wr[2] = c_wr; o_busy[2] = c_busy; o_done[2] = c_done; o_pass[2] = c_pass;
        o_addr[2] = 32'(c_addr); o_in[2] = 32'(c_in); o_err[2] = 32'(c_err); o_ff[2] = 32'(c_ff);
    end

    // Behavioural memories: 1-cycle registered read, write-through, read XOR flip.
    logic [7:0] mem  [NI][256];
    logic [7:0] flip [NI][256];
    logic [7:0] rd   [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (o_wr[i]) begin
                mem[i][o_addr[i][7:0]] <= o_in[i][7:0];
                rd[i] <= o_in[i][7:0];
            end else begin
                rd[i] <= mem[i][o_addr[i][7:0]] ^ flip[i][o_addr[i][7:0]];
            end
        end
    end

    assign a_out = rd[0];
    assign b_out = rd[1];
    assign c_out = rd[2][3:0];

    function automatic int cnt_of(input int i);
        case (i)
            0:       return 4;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input int i);
        return (i == 2) ? 32'h0000_000F : 32'h0000_00FF;
    endfunction

    function automatic logic [31:0] pat(input int i, input int a);
        return (32'(a) ^ 32'h0000_005A) & mask_of(i);
    endfunction

    // mode 0: clean; 1: word w reads back as 0; 2: random subset corrupted.
    task automatic set_flips(input int i, input int mode, input int w);
        for (int a = 0; a < 256; a++) flip[i][a] = 8'h00;
        if (mode == 1) begin
            flip[i][w] = 8'(pat(i, w));
        end else if (mode == 2) begin
            for (int a = 0; a < cnt_of(i); a++)
                if ($urandom_range(0, 2) == 0)
                    flip[i][a] = 8'($urandom_range(1, int'(mask_of(i))));
        end
    endtask

    // One (or, with hold, two back-to-back) complete test on instance i.
    task automatic run_test(input int i, input bit hold, input int pulse_k, input string tag);
        int c, len, runs, kk, exp_err, exp_ff;
        logic [66:0] got, exp;
        logic [64:0] got_r, exp_r;
        logic [31:0] ea, ei;
        c = cnt_of(i);
        len = 2 * c + 2;
        runs = hold ? 2 : 1;
        exp_err = 0;
        exp_ff = 0;
        for (int a = 0; a < c; a++) begin
            if (flip[i][a] != 8'h00) begin
                if (exp_err == 0) exp_ff = a;
                exp_err++;
            end
        end
        @(negedge clk);
        start[i] = 1'b1;
        for (int k = 1; k <= runs * len; k++) begin
            @(negedge clk);
            kk = (k - 1) % len + 1;
            ea = (kk <= c) ? 32'(kk - 1) : ((kk <= 2 * c) ? 32'(kk - c - 1) : 32'd0);
            ei = (kk <= c) ? pat(i, kk - 1) : 32'd0;
            exp = {(kk <= c), ea, ei, (kk <= 2 * c + 1), (kk == len)};
            got = {o_wr[i], o_addr[i], o_in[i], o_busy[i], o_done[i]};
            total++;
            if (got !== exp)
                $display("FAIL %s inst%0d cycle %0d wr/addr/in/busy/done: got %h want %h", tag, i, kk, got, exp);
            else passed++;
            got_r = {o_err[i], o_ff[i], o_pass[i]};
            if (kk == 1) begin
                total++;
                if (got_r !== 65'd0)
                    $display("FAIL %s inst%0d cleared errors/first_fail/pass: got %h want 0", tag, i, got_r);
                else passed++;
            end
            if (kk == len) begin
                exp_r = {32'(exp_err), 32'(exp_ff), (exp_err == 0)};
                total++;
                if (got_r !== exp_r)
                    $display("FAIL %s inst%0d result errors/first_fail/pass: got %h want %h", tag, i, got_r, exp_r);
                else passed++;
            end
            start[i] = hold ? (k < runs * len) : (k == pulse_k);
        end
        @(negedge clk);
        total++;
        if ({o_wr[i], o_addr[i], o_busy[i], o_done[i], o_err[i]} !== {1'b0, 32'd0, 1'b0, 1'b1, 32'(exp_err)})
            $display("FAIL %s inst%0d done hold: got wr=%b addr=%0d busy=%b done=%b err=%0d want 0/0/0/1/%0d",
                     tag, i, o_wr[i], o_addr[i], o_busy[i], o_done[i], o_err[i], exp_err);
        else passed++;
        for (int a = 0; a < c; a++) begin
            total++;
            if (mem[i][a] !== 8'(pat(i, a)))
                $display("FAIL %s inst%0d memory word %0d: got %h want %h", tag, i, a, mem[i][a], 8'(pat(i, a)));
            else passed++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            total++;
            if ({o_wr[i], o_addr[i], o_in[i], o_busy[i], o_done[i], o_pass[i], o_err[i], o_ff[i]} !== 133'd0)
                $display("FAIL %s inst%0d outputs: got wr=%b addr=%h in=%h busy=%b done=%b pass=%b err=%h ff=%h want all 0",
                         tag, i, o_wr[i], o_addr[i], o_in[i], o_busy[i], o_done[i], o_pass[i], o_err[i], o_ff[i]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");
    endtask

    task automatic test_clean();
        set_flips(0, 0, 0);
        run_test(0, 1'b0, 0, "clean");
    endtask

    task automatic test_corrupt();
        set_flips(0, 1, 2);
        run_test(0, 1'b0, 0, "corrupt");
    endtask

    task automatic test_start_while_busy();
        set_flips(0, 1, 2);
        run_test(0, 1'b0, 3, "busy_start");
        set_flips(0, 0, 0);
        run_test(0, 1'b0, 0, "rerun");
    endtask

    task automatic test_reset_midrun();
        set_flips(0, 0, 0);
        @(negedge clk);
        start[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        reset = 1'b1;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        check_all_zero("mid_reset_held");
        reset = 1'b0;
        run_test(0, 1'b0, 0, "post_reset");
    endtask

    task automatic test_count8();
        set_flips(1, 0, 0);
        run_test(1, 1'b0, 0, "count8");
        set_flips(1, 2, 0);
        run_test(1, 1'b0, 0, "count8_rand");
    endtask

    task automatic test_count1();
        set_flips(2, 0, 0);
        run_test(2, 1'b0, 0, "count1");
        set_flips(2, 1, 0);
        run_test(2, 1'b0, 0, "count1_bad");
    endtask

    task automatic test_back_to_back();
        set_flips(0, 2, 0);
        run_test(0, 1'b1, 0, "b2b_a");
        set_flips(2, 0, 0);
        run_test(2, 1'b1, 0, "b2b_c");
    endtask

    task automatic test_random();
        int i, gap, pk;
        for (int n = 0; n < 8; n++) begin
            i = $urandom_range(0, NI - 1);
            set_flips(i, 2, 0);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            pk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * cnt_of(i) + 1) : 0;
            run_test(i, 1'b0, pk, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            for (int a = 0; a < 256; a++) flip[i][a] = 8'h00;
        end
        test_reset();
        test_clean();
        test_corrupt();
        test_start_while_busy();
        test_reset_midrun();
        test_count8();
        test_count1();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
